// File: rtl/tc_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register map,
// CTRL field layout, mode encodings and the controller state encoding.
package tc_timer_pkg;

    // Register offsets within the 16-byte window
    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_PRESET = 4'h4;
    localparam logic [3:0] OFF_COUNT  = 4'h8;
    localparam logic [3:0] OFF_RSVD   = 4'hC;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // MODE encodings; 2'b10 and 2'b11 fall back to one-shot behaviour
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Controller states, shared with the bus bridge and the bench
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

endpackage

// File: rtl/tc_timer.sv
// Memory-mapped countdown timer. CTRL/PRESET are CPU-writable, COUNT is
// read-only. One-shot mode holds its interrupt until CTRL is rewritten;
// auto-reload mode pulses the interrupt for one cycle and restarts.
module tc_timer
    import tc_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic        sel;
    logic [3:0]  offset;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_preset;

    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] count_nxt;
    logic        flag_set;
    logic        flag_clr;
    logic        en_clr;
    logic [1:0]  mode;

    // Word-aligned decode only; the low address bits carry no register select.
    logic        unused_addr;
    assign unused_addr = ^addr[1:0];

    assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset    = addr[3:0];
    assign wr        = sel & we & (byteen == 4'b1111);
    assign wr_ctrl   = wr & (offset == OFF_CTRL);
    assign wr_preset = wr & (offset == OFF_PRESET);
    assign mode      = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];

    // Controller state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state, counter update and interrupt flag requests
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        flag_set  = 1'b0;
        flag_clr  = 1'b0;
        en_clr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctrl[CTRL_EN]) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                count_nxt = preset;
                state_nxt = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl[CTRL_EN]) begin
                    state_nxt = ST_IDLE;
                end else if (count > 32'd1) begin
                    count_nxt = count - 32'd1;
                end else begin
                    // PRESET=0 lands here too, so it behaves like PRESET=1
                    count_nxt = '0;
                    flag_set  = 1'b1;
                    state_nxt = ST_INT;
                end
            end
            ST_INT: begin
                state_nxt = ST_IDLE;
                if (mode == MODE_RELOAD) flag_clr = 1'b1;
                else                     en_clr   = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // COUNT register, only ever written by the controller
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count <= '0;
        else       count <= count_nxt;
    end

    // CTRL register; a CPU write takes priority over the one-shot EN clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        ctrl <= '0;
        else if (wr_ctrl) ctrl <= wdata[3:0];
        else if (en_clr)  ctrl[CTRL_EN] <= 1'b0;
    end

    // PRESET register; a running count is unaffected until the next LOAD
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          preset <= '0;
        else if (wr_preset) preset <= wdata;
    end

    // Interrupt flag: set on expiry, cleared by reload completion or any CTRL write
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    irq_flag <= 1'b0;
        else if (flag_set)            irq_flag <= 1'b1;
        else if (flag_clr | wr_ctrl)  irq_flag <= 1'b0;
    end

    assign irq = irq_flag & ctrl[CTRL_IM];

    // Combinational register readback
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (offset)
                OFF_CTRL:   rdata = {28'd0, ctrl};
                OFF_PRESET: rdata = preset;
                OFF_COUNT:  rdata = count;
                OFF_RSVD:   rdata = '0;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_tc_timer.sv
// Self-checking bench for tc_timer: register access, one-shot and
// auto-reload timing, masking, ignored writes, collisions and reset.
module tb_tc_timer;
    import tc_timer_pkg::*;

    localparam logic [31:0] BASE     = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL   = BASE + 32'h0;
    localparam logic [31:0] A_PRESET = BASE + 32'h4;
    localparam logic [31:0] A_COUNT  = BASE + 32'h8;
    localparam logic [31:0] A_RSVD   = BASE + 32'hC;
    localparam logic [31:0] A_OUT    = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_cnt_q[$];
    logic        exp_irq_q[$];

    tc_timer #(.BASE_ADDR(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .we     (we),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] mk_ctrl(input logic en, input logic [1:0] md, input logic im);
        return {28'd0, im, md, en};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr   = a;
        wdata  = d;
        byteen = be;
        we     = 1'b1;
        @(negedge clk);
        we     = 1'b0;
        byteen = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic do_reset();
        we = 1'b0; byteen = 4'h0; wdata = '0; addr = A_CTRL;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        bus_read(A_CTRL, d);   checks++; if (d !== 32'd0) $display("FAIL reset_ctrl: got %0h expected 0", d);   if (d !== 32'd0) errors++;
        bus_read(A_PRESET, d); checks++; if (d !== 32'd0) $display("FAIL reset_preset: got %0h expected 0", d); if (d !== 32'd0) errors++;
        bus_read(A_COUNT, d);  checks++; if (d !== 32'd0) $display("FAIL reset_count: got %0h expected 0", d);  if (d !== 32'd0) errors++;
        bus_read(A_RSVD, d);   checks++; if (d !== 32'd0) $display("FAIL reset_rsvd: got %0h expected 0", d);   if (d !== 32'd0) errors++;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    endtask

    task automatic test_oneshot();
        logic [31:0] d, ec;
        logic        ei;
        do_reset();
        bus_write(A_PRESET, 32'd5, 4'hF);
        bus_write(A_CTRL, mk_ctrl(1'b1, MODE_ONESHOT, 1'b1), 4'hF);
        step(); // LOAD
        for (int v = 5; v >= 0; v--) begin
            exp_cnt_q.push_back(32'(v));
            exp_irq_q.push_back(v == 0);
        end
        while (exp_cnt_q.size() > 0) begin
            step();
            bus_read(A_COUNT, d);
            ec = exp_cnt_q.pop_front();
            ei = exp_irq_q.pop_front();
            checks++; if (d !== ec) begin errors++; $display("FAIL oneshot_count: got %0d expected %0d", d, ec); end
            checks++; if (irq !== ei) begin errors++; $display("FAIL oneshot_irq: got %b expected %b (count %0d)", irq, ei, ec); end
        end
        step(); // INT -> IDLE clears EN
        bus_read(A_CTRL, d);
        checks++; if (d !== 32'h8) begin errors++; $display("FAIL oneshot_en_clear: got %0h expected 8", d); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq_held: got %b expected 1", irq); end
        end
        bus_write(A_CTRL, 32'h8, 4'hF);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_ack: got %b expected 0", irq); end
        step();
        bus_read(A_COUNT, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL oneshot_stopped: got %0d expected 0", d); end
    endtask

    task automatic test_autoreload();
        logic [31:0] d, ec;
        logic        ei;
        logic [31:0] cnt_tab[6];
        int          p;
        cnt_tab = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
        do_reset();
        bus_write(A_PRESET, 32'd3, 4'hF);
        bus_write(A_CTRL, mk_ctrl(1'b1, MODE_RELOAD, 1'b1), 4'hF);
        // Period of PRESET+3 cycles: count 3,2,1 then INT, IDLE, LOAD
        for (int k = 1; k <= 19; k++) begin
            p = (k + 4) % 6;
            exp_cnt_q.push_back(cnt_tab[p]);
            exp_irq_q.push_back(p == 3);
        end
        while (exp_cnt_q.size() > 0) begin
            step();
            bus_read(A_COUNT, d);
            ec = exp_cnt_q.pop_front();
            ei = exp_irq_q.pop_front();
            checks++; if (d !== ec) begin errors++; $display("FAIL reload_count: got %0d expected %0d", d, ec); end
            checks++; if (irq !== ei) begin errors++; $display("FAIL reload_irq: got %b expected %b", irq, ei); end
        end
        bus_read(A_CTRL, d);
        checks++; if (d !== 32'hB) begin errors++; $display("FAIL reload_ctrl_kept: got %0h expected b", d); end
    endtask

    task automatic test_mask();
        logic [31:0] d;
        do_reset();
        bus_write(A_PRESET, 32'd2, 4'hF);
        bus_write(A_CTRL, mk_ctrl(1'b1, MODE_ONESHOT, 1'b0), 4'hF);
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq: got %b expected 0 (cycle %0d)", irq, k); end
        end
        bus_read(A_COUNT, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL mask_count: got %0d expected 0", d); end
        bus_read(A_CTRL, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL mask_en_clear: got %0h expected 0", d); end
        bus_write(A_CTRL, 32'h8, 4'hF);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_unmask: got %b expected 0", irq); end
        step();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_unmask_later: got %b expected 0", irq); end
    endtask

    task automatic test_ignored_writes();
        logic [31:0] d;
        do_reset();
        bus_write(A_PRESET, 32'h0000_1234, 4'hF);
        bus_write(A_PRESET, 32'h0000_FFFF, 4'b0011);
        bus_read(A_PRESET, d);
        checks++; if (d !== 32'h1234) begin errors++; $display("FAIL ign_partial: got %0h expected 1234", d); end
        bus_write(A_COUNT, 32'h0000_FFFF, 4'hF);
        bus_read(A_COUNT, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL ign_count: got %0h expected 0", d); end
        bus_write(A_OUT, 32'hFFFF_FFFF, 4'hF);
        bus_read(A_PRESET, d);
        checks++; if (d !== 32'h1234) begin errors++; $display("FAIL ign_unsel_preset: got %0h expected 1234", d); end
        bus_read(A_CTRL, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL ign_unsel_ctrl: got %0h expected 0", d); end
        bus_write(A_RSVD, 32'hFFFF_FFFF, 4'hF);
        bus_read(A_RSVD, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL ign_rsvd: got %0h expected 0", d); end
        bus_write(A_PRESET - 32'h10, 32'h0, 4'hF);
        bus_read(BASE + 32'h14, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL unsel_read: got %0h expected 0", d); end
        bus_write(A_CTRL, 32'hFFFF_FFF0, 4'hF);
        bus_read(A_CTRL, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL ctrl_upper: got %0h expected 0", d); end
    endtask

    task automatic test_int_collision();
        logic [31:0] d;
        do_reset();
        bus_write(A_PRESET, 32'd0, 4'hF);
        bus_write(A_CTRL, mk_ctrl(1'b1, MODE_ONESHOT, 1'b1), 4'hF);
        step(); // LOAD
        step(); // CNT with COUNT=0
        bus_read(A_COUNT, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL coll_count0: got %0d expected 0", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL coll_irq_early: got %b expected 0", irq); end
        step(); // INT
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL coll_preset0_irq: got %b expected 1", irq); end
        // CTRL write on the same edge the one-shot would clear EN
        bus_write(A_CTRL, 32'h9, 4'hF);
        bus_read(A_CTRL, d);
        checks++; if (d !== 32'h9) begin errors++; $display("FAIL coll_ctrl_wins: got %0h expected 9", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL coll_irq_cleared: got %b expected 0", irq); end
        step(); step(); step();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL coll_rerun_irq: got %b expected 1", irq); end
    endtask

    task automatic test_midrun();
        logic [31:0] d, ec;
        do_reset();
        bus_write(A_PRESET, 32'd10, 4'hF);
        bus_write(A_CTRL, 32'h9, 4'hF);
        for (int i = 0; i < 5; i++) step();
        bus_read(A_COUNT, d);
        checks++; if (d !== 32'd7) begin errors++; $display("FAIL mid_count7: got %0d expected 7", d); end
        exp_cnt_q.push_back(32'd6);
        exp_cnt_q.push_back(32'd5);
        bus_write(A_PRESET, 32'd2, 4'hF);
        bus_read(A_COUNT, d);
        ec = exp_cnt_q.pop_front();
        checks++; if (d !== ec) begin errors++; $display("FAIL mid_preset_run: got %0d expected %0d", d, ec); end
        step();
        bus_read(A_COUNT, d);
        ec = exp_cnt_q.pop_front();
        checks++; if (d !== ec) begin errors++; $display("FAIL mid_preset_run: got %0d expected %0d", d, ec); end
        bus_read(A_PRESET, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL mid_preset_val: got %0d expected 2", d); end
        // EN=0 write: the write edge still decrements, then COUNT freezes
        bus_write(A_CTRL, 32'h8, 4'hF);
        for (int i = 0; i < 3; i++) begin
            step();
            bus_read(A_COUNT, d);
            checks++; if (d !== 32'd4) begin errors++; $display("FAIL mid_freeze: got %0d expected 4", d); end
        end
        bus_write(A_CTRL, 32'h9, 4'hF);
        step(); step();
        bus_read(A_COUNT, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL mid_restart: got %0d expected 2", d); end
        // Asynchronous reset between edges
        #2 reset = 1'b1;
        bus_read(A_COUNT, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL areset_count: got %0d expected 0", d); end
        bus_read(A_PRESET, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL areset_preset: got %0d expected 0", d); end
        bus_read(A_CTRL, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL areset_ctrl: got %0h expected 0", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL areset_irq: got %b expected 0", irq); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; byteen = 4'h0; wdata = '0; addr = '0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_mask();
        test_ignored_writes();
        test_int_collision();
        test_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
